// File: rtl/dmem_mmio_unit.sv
// Data-side memory unit for the RV32 MEM stage: byte-lane word RAM with load
// extension and misalignment trapping, plus an MMIO window (LED, cycle counter, TX FIFO, status).
module dmem_mmio_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    REG_LED    = 2'd0,
    REG_TX     = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_STATUS = 2'd3
  } mmio_reg_e;

  // Shift the addressed lane(s) down and extend according to the access type.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  t);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (t)
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return {16'b0, sh[15:0]};
      3'b011:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'b0, sh[7:0]};
      default: return word;
    endcase
  endfunction

  logic            is_half, is_byte, misaligned;
  logic            in_ram, in_mmio;
  mmio_reg_e       reg_sel;
  logic [AW-1:0]   word_idx;
  logic [3:0]      lane_be;
  logic [31:0]     lane_wdata;
  logic            store_ok, ram_we, mmio_we;
  logic            led_we, push, status_clr;

  logic [31:0]     ram [DEPTH_WORDS];
  logic [15:0]     led_q;
  logic [31:0]     cycle_q;
  logic [7:0]      fifo_mem [4];
  logic [1:0]      rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [2:0]      count, count_nxt;
  logic            overflow;
  logic            pop, full, push_ok, push_drop;
  logic [7:0]      head_nxt;

  always_comb begin
    is_half    = (dm_type == 3'b001) || (dm_type == 3'b010);
    is_byte    = (dm_type == 3'b011) || (dm_type == 3'b100);
    misaligned = (is_half && addr[0]) || (!is_half && !is_byte && (addr[1:0] != 2'b00));
    in_ram     = ({1'b0, addr} < RAM_BYTES);
    in_mmio    = (addr[31:4] == MMIO_BASE[31:4]);
    reg_sel    = mmio_reg_e'(addr[3:2]);
    word_idx   = addr[AW+1:2];
  end

  // Store lane steering: replicate the source so any enabled lane sees the right bytes.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = wdata;
    if (is_byte) begin
      lane_be    = 4'b0001 << addr[1:0];
      lane_wdata = {4{wdata[7:0]}};
    end else if (is_half) begin
      lane_be    = addr[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    store_ok   = mem_we && !misaligned;
    ram_we     = store_ok && in_ram && !reset;
    mmio_we    = store_ok && in_mmio;
    led_we     = mmio_we && (reg_sel == REG_LED);
    push       = mmio_we && (reg_sel == REG_TX);
    status_clr = mmio_we && (reg_sel == REG_STATUS);
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) ram[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push when draining.
  always_comb begin
    pop        = tx_valid && tx_ready;
    full       = (count == 3'd4);
    push_ok    = push && (!full || pop);
    push_drop  = push && full && !pop;
    rd_ptr_nxt = rd_ptr + {1'b0, pop};
    count_nxt  = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 3'd1;
      2'b01:   count_nxt = count - 3'd1;
      default: count_nxt = count;
    endcase
    head_nxt = fifo_mem[rd_ptr_nxt];
    if (push_ok && (rd_ptr_nxt == wr_ptr)) head_nxt = wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q        <= '0;
      cycle_q      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      cycle_q  <= cycle_q + 32'd1;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      tx_valid <= (count_nxt != 3'd0);
      tx_data  <= head_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (led_we) led_q <= wdata[15:0];
      if (status_clr) begin
        overflow     <= 1'b0;
        misalign_err <= 1'b0;
        err_addr     <= '0;
      end else begin
        if (push_drop) overflow <= 1'b1;
        // Only the first trapping store since the last clear is recorded.
        if (mem_we && misaligned && !misalign_err) begin
          misalign_err <= 1'b1;
          err_addr     <= addr;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!misaligned) begin
      if (in_ram) begin
        rdata = load_extend(ram[word_idx], addr[1:0], dm_type);
      end else if (in_mmio) begin
        case (reg_sel)
          REG_LED:    rdata = {16'b0, led_q};
          REG_TX:     rdata = {27'b0, overflow, count, (count == 3'd0)};
          REG_CYCLE:  rdata = cycle_q;
          REG_STATUS: rdata = {30'b0, overflow, misalign_err};
          default:    rdata = '0;
        endcase
      end
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Self-checking bench for dmem_mmio_unit: directed scenarios plus randomized traffic
// compared against a byte-array / queue reference model.
module tb_dmem_mmio_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  dm_type = '0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        misalign_err;
  logic [31:0] err_addr;

  int n_cmp = 0;
  int n_fail = 0;

  dmem_mmio_unit dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .addr(addr), .wdata(wdata),
    .dm_type(dm_type), .rdata(rdata), .led(led), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .misalign_err(misalign_err),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mb [0:4095];
  logic [15:0] m_led = '0;
  logic [31:0] m_cycle = '0;
  logic [7:0]  m_q [$];
  logic        m_ovf = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_eaddr = '0;
  bit          m_pop;

  function automatic int acc_size(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 2;
    if (t == 3'd3 || t == 3'd4) return 1;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] t);
    int sz;
    sz = acc_size(t);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
    int sz;
    logic [31:0] v;
    logic [2:0] cnt;
    sz = acc_size(t);
    if (is_mis(a, t)) return 32'h0;
    if (a < 32'd4096) begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[a + i];
      if (t == 3'd1) v = {{16{v[15]}}, v[15:0]};
      if (t == 3'd3) v = {{24{v[7]}}, v[7:0]};
      return v;
    end
    if (a[31:4] == 28'hFFFF000) begin
      cnt = 3'(m_q.size());
      case (a[3:2])
        2'd0: return {16'h0, m_led};
        2'd1: return {27'h0, m_ovf, cnt, (m_q.size() == 0)};
        2'd2: return m_cycle;
        default: return {30'h0, m_ovf, m_err};
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    int sz;
    sz = acc_size(t);
    if (is_mis(a, t)) begin
      if (!m_err) begin
        m_err = 1'b1;
        m_eaddr = a;
      end
    end else if (a < 32'd4096) begin
      for (int i = 0; i < sz; i++) mb[a + i] = d[8*i +: 8];
    end else if (a[31:4] == 28'hFFFF000) begin
      case (a[3:2])
        2'd0: m_led = d[15:0];
        2'd1: if (m_q.size() < 4) m_q.push_back(d[7:0]); else m_ovf = 1'b1;
        2'd3: begin m_ovf = 1'b0; m_err = 1'b0; m_eaddr = '0; end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_led = '0; m_cycle = '0; m_q.delete(); m_ovf = 1'b0; m_err = 1'b0; m_eaddr = '0;
    end else begin
      m_pop = tx_ready && (m_q.size() > 0);
      m_cycle = m_cycle + 32'd1;
      if (m_pop) void'(m_q.pop_front());
      if (mem_we) model_store(addr, wdata, dm_type);
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    @(negedge clk);
    addr = a; wdata = d; dm_type = t; mem_we = 1'b1;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] t);
    @(negedge clk);
    mem_we = 1'b0; addr = a; dm_type = t;
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    addr = 32'hFFFF_0008; dm_type = 3'd0;
    #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cycle got %h want %h", rdata, 32'h0); end
    n_cmp++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led got %h want %h", led, 16'h0); end
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_tx got %b/%h want 0/00", tx_valid, tx_data); end
    n_cmp++; if (misalign_err !== 1'b0 || err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_err got %b/%h want 0/0", misalign_err, err_addr); end
  endtask

  task automatic test_byte_lanes;
    do_store(32'h10, 32'h1122_3344, 3'd0);
    do_store(32'h12, 32'h5555_55AB, 3'd3);
    set_load(32'h10, 3'd0);
    n_cmp++; if (rdata !== 32'h11AB_3344) begin n_fail++; $display("FAIL lw_lanes got %h want %h", rdata, 32'h11AB_3344); end
    set_load(32'h12, 3'd3);
    n_cmp++; if (rdata !== 32'hFFFF_FFAB) begin n_fail++; $display("FAIL lb got %h want %h", rdata, 32'hFFFF_FFAB); end
    set_load(32'h12, 3'd4);
    n_cmp++; if (rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL lbu got %h want %h", rdata, 32'h0000_00AB); end
  endtask

  task automatic test_half;
    do_store(32'h20, 32'hCAFE_1234, 3'd0);
    do_store(32'h22, 32'h7777_8001, 3'd1);
    set_load(32'h22, 3'd1);
    n_cmp++; if (rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh got %h want %h", rdata, 32'hFFFF_8001); end
    set_load(32'h22, 3'd2);
    n_cmp++; if (rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu got %h want %h", rdata, 32'h0000_8001); end
    set_load(32'h20, 3'd0);
    n_cmp++; if (rdata !== 32'h8001_1234) begin n_fail++; $display("FAIL lw_half got %h want %h", rdata, 32'h8001_1234); end
  endtask

  task automatic test_misalign;
    do_store(32'h30, 32'h5566_7788, 3'd0);
    do_store(32'h31, 32'hDEAD_BEEF, 3'd0);
    set_load(32'h30, 3'd0);
    n_cmp++; if (rdata !== 32'h5566_7788) begin n_fail++; $display("FAIL mis_ram got %h want %h", rdata, 32'h5566_7788); end
    n_cmp++; if (misalign_err !== 1'b1 || err_addr !== 32'h31) begin n_fail++; $display("FAIL mis_capture got %b/%h want 1/00000031", misalign_err, err_addr); end
    do_store(32'h45, 32'h0000_1234, 3'd1);
    #1;
    n_cmp++; if (err_addr !== 32'h31) begin n_fail++; $display("FAIL mis_keep got %h want %h", err_addr, 32'h31); end
    set_load(32'h31, 3'd0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mis_load got %h want %h", rdata, 32'h0); end
    do_store(32'hFFFF_000C, 32'h0, 3'd0);
    #1;
    n_cmp++; if (misalign_err !== 1'b0 || err_addr !== 32'h0) begin n_fail++; $display("FAIL mis_clear got %b/%h want 0/0", misalign_err, err_addr); end
    set_load(32'h31, 3'd0);
    set_load(32'h31, 3'd2);
    set_load(32'h44, 3'd0);
    n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_load_notrap got %b want 0", misalign_err); end
  endtask

  task automatic test_fifo_overflow;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_store(32'hFFFF_0004, 32'h41 + i, 3'd4);
    set_load(32'hFFFF_0004, 3'd0);
    n_cmp++; if (rdata !== 32'h18) begin n_fail++; $display("FAIL ovf_txreg got %h want %h", rdata, 32'h18); end
    set_load(32'hFFFF_000C, 3'd0);
    n_cmp++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL ovf_status got %h want %h", rdata, 32'h2); end
    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        n_fail++; $display("FAIL ovf_drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      @(negedge clk);
      #1;
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", tx_valid); end
    tx_ready = 1'b0;
    do_store(32'hFFFF_000C, 32'h0, 3'd0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h61, 8'h62, 8'h63, 8'h50};
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_store(32'hFFFF_0004, 32'h60 + i, 3'd0);
    @(negedge clk);
    addr = 32'hFFFF_0004; wdata = 32'h50; dm_type = 3'd0; mem_we = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    mem_we = 1'b0; tx_ready = 1'b0;
    #1;
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h61) begin n_fail++; $display("FAIL pp_head got %b/%h want 1/61", tx_valid, tx_data); end
    n_cmp++; if (rdata !== 32'h08) begin n_fail++; $display("FAIL pp_txreg got %h want %h", rdata, 32'h08); end
    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
        n_fail++; $display("FAIL pp_drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, exp_seq[i]);
      end
      @(negedge clk);
      #1;
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_random;
    int op;
    logic [31:0] a, e;
    for (int w = 0; w < 64; w++) do_store(32'(w * 4), $urandom, 3'd0);
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      op = $urandom_range(0, 9);
      tx_ready = 1'($urandom_range(0, 1));
      dm_type = 3'($urandom_range(0, 7));
      wdata = $urandom;
      mem_we = 1'b0;
      if (op <= 5) a = 32'($urandom_range(0, 255));
      else if (op <= 7) a = 32'hFFFF_0000 + 32'($urandom_range(0, 15));
      else a = 32'h8000_0000 + 32'($urandom_range(0, 15));
      if (op == 4 || op == 5 || op == 6 || op == 8) mem_we = 1'b1;
      addr = a;
      #1;
      e = model_load(a, dm_type);
      n_cmp++; if (rdata !== e) begin n_fail++; $display("FAIL rnd_rdata it%0d a=%h t=%0d got %h want %h", it, a, dm_type, rdata, e); end
      n_cmp++; if (tx_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_txvalid it%0d got %b want %0d", it, tx_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        n_cmp++; if (tx_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_txdata it%0d got %h want %h", it, tx_data, m_q[0]); end
      end
      n_cmp++; if (misalign_err !== m_err || err_addr !== m_eaddr) begin n_fail++; $display("FAIL rnd_err it%0d got %b/%h want %b/%h", it, misalign_err, err_addr, m_err, m_eaddr); end
      n_cmp++; if (led !== m_led) begin n_fail++; $display("FAIL rnd_led it%0d got %h want %h", it, led, m_led); end
    end
    @(negedge clk);
    mem_we = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic test_reset_mmio;
    logic [31:0] c0;
    do_store(32'hFFFF_0000, 32'h1234_BEEF, 3'd0);
    set_load(32'hFFFF_0000, 3'd3);
    n_cmp++; if (rdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL led_read got %h want %h", rdata, 32'h0000_BEEF); end
    set_load(32'hFFFF_0008, 3'd0);
    c0 = rdata;
    repeat (10) @(negedge clk);
    set_load(32'hFFFF_0008, 3'd0);
    n_cmp++; if (rdata !== c0 + 32'd11) begin n_fail++; $display("FAIL cycle_delta got %h want %h", rdata, c0 + 32'd11); end
    do_store(32'hFFFF_0004, 32'h77, 3'd4);
    addr = 32'hFFFF_0008; dm_type = 3'd0;
    #1;
    n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_tx got %b want 1", tx_valid); end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (led !== 16'h0) begin n_fail++; $display("FAIL areset_led got %h want 0000", led); end
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin n_fail++; $display("FAIL areset_tx got %b/%h want 0/00", tx_valid, tx_data); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL areset_cycle got %h want 0", rdata); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL release_cycle got %h want 0", rdata); end
    set_load(32'h8000_0000, 3'd0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h want 0", rdata); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_lanes();
    test_half();
    test_misalign();
    test_fifo_overflow();
    test_back_to_back();
    test_random();
    test_reset_mmio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
